// File: rtl/spu_env_rate_sched_if.sv
// spu_env_rate_sched_if
// Bundles every non-clock signal of the envelope rate scheduler.
//   master : scheduler side. It drives the rate request, the ROM address/strobe,
//            the step events and the status flags.
//   slave  : environment side. It covers the voice register file, the rate ROM,
//            the key-on source and the envelope level logic.
// Signals:
//   sample_tick        tick pulse that starts a sweep
//   rate_voice/rate_idx  voice requested / its rate index (combinational return)
//   rom_adrs/rom_read  ROM address and read strobe; rom_dout arrives one cycle later
//   key_on/key_voice   counter clear request
//   step_valid/step_voice  step event for one voice
//   busy/done/overrun  sweep status
interface spu_env_rate_sched_if #(
    parameter int VW = 5
);
    logic          sample_tick;
    logic [VW-1:0] rate_voice;
    logic [6:0]    rate_idx;
    logic [6:0]    rom_adrs;
    logic          rom_read;
    logic [13:0]   rom_dout;
    logic          key_on;
    logic [VW-1:0] key_voice;
    logic          step_valid;
    logic [VW-1:0] step_voice;
    logic          busy;
    logic          done;
    logic          overrun;

    modport master (
        input  sample_tick, rate_idx, rom_dout, key_on, key_voice,
        output rate_voice, rom_adrs, rom_read, step_valid, step_voice,
        output busy, done, overrun
    );

    modport slave (
        output sample_tick, rate_idx, rom_dout, key_on, key_voice,
        input  rate_voice, rom_adrs, rom_read, step_valid, step_voice,
        input  busy, done, overrun
    );
endinterface

// File: rtl/spu_env_rate_sched.sv
// spu_env_rate_sched
// Time-multiplexed scheduler for the shared ADSR rate-table ROM. Each sample
// tick sweeps voices 0..NVOICE-1, one ROM read per cycle. Each returned
// increment is accumulated into a 15-bit per-voice counter. When the sum
// reaches 0x8000, a step event is emitted and the counter restarts at 0.
// Ports:
//   m_clock  system clock (rising edge)
//   p_reset  asynchronous active-high reset
//   bus      spu_env_rate_sched_if.master (see interface header)
// Optional feature macro: SPU_ENV_OVERRUN_EN. When it is defined, a sticky
// overrun flag latches a tick that arrives mid-sweep. When it is undefined,
// overrun is tied to 0.
module spu_env_rate_sched #(
    parameter int NVOICE = 24,
    parameter int VW     = 5
) (
    input logic                      m_clock,
    input logic                      p_reset,
    spu_env_rate_sched_if.master     bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [VW-1:0] LAST = VW'(NVOICE - 1);

    state_t        r_state;
    logic [VW-1:0] r_v;
    logic [VW-1:0] r_v_d;
    logic          r_vld_d;
    logic          r_rom_read;
    logic          r_busy;
    logic          r_done;
    logic          r_step_valid;
    logic [VW-1:0] r_step_voice;
    // Counters never reach 0x8000, so 15 bits of storage suffice.
    logic [14:0]   r_cnt [NVOICE];

    logic [14:0]   w_cur;
    logic [15:0]   w_sum;
    logic          w_kill;
    logic          w_tick_ok;

    assign w_cur  = r_cnt[r_v_d];
    assign w_sum  = {1'b0, w_cur} + {2'b00, bus.rom_dout};
    // A key-on aimed at the voice being written back overrides the update.
    assign w_kill = bus.key_on && (bus.key_voice == r_v_d);
    // A tick is accepted whenever the FSM is idle. This includes the done
    // cycle, so ticks spaced NVOICE+2 cycles apart run back to back.
    assign w_tick_ok = bus.sample_tick && (r_state == S_IDLE);

    // r_v is held at 0 outside RUN, so it can drive rate_voice directly.
    assign bus.rate_voice = r_v;
    assign bus.rom_read   = r_rom_read;
    assign bus.rom_adrs   = r_rom_read ? bus.rate_idx : 7'd0;
    assign bus.step_valid = r_step_valid;
    assign bus.step_voice = r_step_voice;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_state      <= S_IDLE;
            r_v          <= '0;
            r_v_d        <= '0;
            r_vld_d      <= 1'b0;
            r_rom_read   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_step_valid <= 1'b0;
            r_step_voice <= '0;
            for (int i = 0; i < NVOICE; i++) r_cnt[i] <= '0;
        end else begin
            r_done       <= 1'b0;
            r_step_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_tick_ok) begin
                        r_state    <= S_RUN;
                        r_v        <= '0;
                        r_rom_read <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (r_done) begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_v == LAST) begin
                        r_state    <= S_DRAIN;
                        r_v        <= '0;
                        r_rom_read <= 1'b0;
                    end else begin
                        r_v <= r_v + VW'(1);
                    end
                end
                S_DRAIN: begin
                    // The final voice's result is registered on this edge.
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase

            // Issue stage to update stage.
            r_vld_d <= r_rom_read;
            r_v_d   <= r_v;

            if (r_vld_d) begin
                if (w_sum[15]) begin
                    r_cnt[r_v_d] <= '0;
                    r_step_valid <= !w_kill;
                    r_step_voice <= r_v_d;
                end else begin
                    r_cnt[r_v_d] <= w_sum[14:0];
                end
            end

            // This write is placed last so that it takes precedence over the
            // update write above.
            if (bus.key_on && (32'(bus.key_voice) < 32'(NVOICE)))
                r_cnt[bus.key_voice] <= '0;
        end
    end

`ifdef SPU_ENV_OVERRUN_EN
    logic r_overrun;

    // Sticky flag. It is set by a tick that arrives while the FSM is outside
    // IDLE, and only reset clears it.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset)
            r_overrun <= 1'b0;
        else if (bus.sample_tick && (r_state != S_IDLE))
            r_overrun <= 1'b1;
    end

    assign bus.overrun = r_overrun;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spu_env_rate_sched.sv
module tb_spu_env_rate_sched;
    localparam int NVOICE = 24;
    localparam int VW     = 5;
`ifdef SPU_ENV_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    logic [6:0] rate_tab [32];

    spu_env_rate_sched_if #(.VW(VW)) bus ();

    spu_env_rate_sched #(.NVOICE(NVOICE), .VW(VW)) dut (
        .m_clock (clk),
        .p_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Rate-table ROM model: 0x00 -> 14336, 0x23 -> 32, 0x38.. -> 0, other -> r+1
    function automatic logic [13:0] inc(input logic [6:0] r);
        if (r >= 7'h38)      return 14'd0;
        else if (r == 7'h00) return 14'd14336;
        else if (r == 7'h23) return 14'd32;
        else                 return {7'd0, r} + 14'd1;
    endfunction

    assign bus.rate_idx = rate_tab[bus.rate_voice];

    always @(posedge clk or posedge rst) begin
        if (rst) bus.rom_dout <= '0;
        else if (bus.rom_read) bus.rom_dout <= inc(bus.rom_adrs);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // per-sweep observations (k = cycle offset from E0)
    int            s_step_cnt, s_step_k, s_done_cnt, s_done_k, s_busy_cnt, s_rd_cnt, s_seq_bad;
    logic [VW-1:0] s_step_v;

    task automatic set_rates(input logic [6:0] dflt, input int v, input logic [6:0] r);
        for (int i = 0; i < 32; i++) rate_tab[i] = dflt;
        if (v >= 0) rate_tab[v] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one tick, then observe cycles E0+0 .. E0+NVOICE+3 at the negedge.
    // Drives set at offset k are sampled at edge E0+k+1.
    task automatic sweep(input int tick_k, input int ko_k, input logic [VW-1:0] ko_v);
        int exp_v;
        s_step_cnt = 0; s_step_k = -1; s_step_v = '0;
        s_done_cnt = 0; s_done_k = -1; s_busy_cnt = 0; s_rd_cnt = 0; s_seq_bad = 0;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NVOICE + 4; k++) begin
            @(negedge clk);
            if (bus.step_valid) begin s_step_cnt++; s_step_k = k; s_step_v = bus.step_voice; end
            if (bus.done) begin s_done_cnt++; s_done_k = k; end
            if (bus.busy) s_busy_cnt++;
            exp_v = (k < NVOICE + 2) ? k : k - (NVOICE + 2);
            if (bus.rom_read) begin
                s_rd_cnt++;
                if (int'(bus.rate_voice) != exp_v || bus.rom_adrs != rate_tab[exp_v]) s_seq_bad++;
            end else if (bus.rate_voice != '0 || bus.rom_adrs != 7'd0) begin
                s_seq_bad++;
            end
            bus.sample_tick = (k == tick_k);
            bus.key_on      = (k == ko_k);
            bus.key_voice   = (k == ko_k) ? ko_v : '0;
        end
        bus.sample_tick = 1'b0;
        bus.key_on      = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        do_reset();
        @(negedge clk);
        outs = {bus.rom_read, bus.busy, bus.done, bus.step_valid, bus.overrun,
                bus.rate_voice, bus.rom_adrs, bus.step_voice, 10'd0};
        checks++;
        if (outs !== '0) begin
            $display("FAIL reset_outputs: got %h expected 0", outs); fails++;
        end
        // Leave voice 0 holding one increment, then reset mid-sweep.
        set_rates(7'h38, 0, 7'h00);
        sweep(-1, -1, '0);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sample_tick = 1'b0;
        checks++;
        if ({bus.rom_read, bus.busy} !== 2'b11) begin
            $display("FAIL reset_presweep: got %b expected 11", {bus.rom_read, bus.busy}); fails++;
        end
        #1 rst = 1'b1;
        #1;
        outs = {bus.rom_read, bus.busy, bus.done, bus.step_valid, bus.overrun,
                bus.rate_voice, bus.rom_adrs, bus.step_voice, 10'd0};
        checks++;
        if (outs !== '0) begin
            $display("FAIL reset_async: got %h expected 0", outs); fails++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rom_read, bus.busy, bus.step_valid} !== 3'b000) begin
            $display("FAIL reset_abort: got %b expected 000", {bus.rom_read, bus.busy, bus.step_valid}); fails++;
        end
        // Cleared counter: steps only on the third sweep after reset.
        sweep(-1, -1, '0);
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 0) begin
            $display("FAIL reset_cnt_cleared: got %0d steps expected 0", s_step_cnt); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 1 || s_step_k !== 2 || s_step_v !== '0) begin
            $display("FAIL reset_third_step: got n=%0d k=%0d v=%0d expected n=1 k=2 v=0",
                     s_step_cnt, s_step_k, s_step_v); fails++;
        end
    endtask

    task automatic test_rate00();
        int pre;
        do_reset();
        set_rates(7'h38, 0, 7'h00);
        sweep(-1, -1, '0);
        checks++;
        if (s_done_cnt !== 1 || s_done_k !== NVOICE + 1 || s_busy_cnt !== NVOICE + 2 || s_rd_cnt !== NVOICE) begin
            $display("FAIL rate00_timing: got done=%0d@%0d busy=%0d rd=%0d expected 1@%0d %0d %0d",
                     s_done_cnt, s_done_k, s_busy_cnt, s_rd_cnt, NVOICE + 1, NVOICE + 2, NVOICE); fails++;
        end
        pre = s_step_cnt;
        sweep(-1, -1, '0);
        pre += s_step_cnt;
        checks++;
        if (pre !== 0) begin
            $display("FAIL rate00_early: got %0d steps expected 0", pre); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 1 || s_step_k !== 2 || s_step_v !== '0) begin
            $display("FAIL rate00_step: got n=%0d k=%0d v=%0d expected n=1 k=2 v=0",
                     s_step_cnt, s_step_k, s_step_v); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 0) begin
            $display("FAIL rate00_wrap: got %0d steps expected 0", s_step_cnt); fails++;
        end
    endtask

    task automatic test_rate23();
        int tot;
        do_reset();
        set_rates(7'h38, 5, 7'h23);
        tot = 0;
        for (int t = 0; t < 1023; t++) begin
            sweep(-1, -1, '0);
            tot += s_step_cnt;
        end
        checks++;
        if (tot !== 0) begin
            $display("FAIL rate23_early: got %0d steps expected 0", tot); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 1 || s_step_k !== 7 || s_step_v !== 5'd5) begin
            $display("FAIL rate23_step: got n=%0d k=%0d v=%0d expected n=1 k=7 v=5",
                     s_step_cnt, s_step_k, s_step_v); fails++;
        end
    endtask

    task automatic test_zero_rate();
        int steps, rd, dbad, bbad, sbad;
        do_reset();
        set_rates(7'h38, -1, 7'h00);
        steps = 0; rd = 0; dbad = 0; bbad = 0; sbad = 0;
        for (int t = 0; t < 100; t++) begin
            sweep(-1, -1, '0);
            steps += s_step_cnt;
            rd    += s_rd_cnt;
            if (s_done_cnt != 1 || s_done_k != NVOICE + 1) dbad++;
            if (s_busy_cnt != NVOICE + 2) bbad++;
            sbad += s_seq_bad;
        end
        checks++;
        if (steps !== 0) begin
            $display("FAIL zero_steps: got %0d expected 0", steps); fails++;
        end
        checks++;
        if (rd !== 100 * NVOICE) begin
            $display("FAIL zero_rom_reads: got %0d expected %0d", rd, 100 * NVOICE); fails++;
        end
        checks++;
        if (dbad !== 0 || bbad !== 0) begin
            $display("FAIL zero_done_busy: got %0d bad done, %0d bad busy expected 0", dbad, bbad); fails++;
        end
        checks++;
        if (sbad !== 0) begin
            $display("FAIL zero_issue_seq: got %0d bad issue cycles expected 0", sbad); fails++;
        end
    endtask

    task automatic test_keyon_collision();
        int pre;
        do_reset();
        set_rates(7'h38, 3, 7'h00);
        sweep(-1, -1, '0);
        pre = s_step_cnt;
        sweep(-1, -1, '0);
        pre += s_step_cnt;
        // voice 3 updates on edge E0+5: key_on driven at offset 4
        sweep(-1, 4, 5'd3);
        pre += s_step_cnt;
        checks++;
        if (pre !== 0) begin
            $display("FAIL keyon_suppress: got %0d steps expected 0", pre); fails++;
        end
        sweep(-1, -1, '0);
        pre = s_step_cnt;
        sweep(-1, -1, '0);
        pre += s_step_cnt;
        checks++;
        if (pre !== 0) begin
            $display("FAIL keyon_cleared: got %0d steps expected 0", pre); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (s_step_cnt !== 1 || s_step_k !== 5 || s_step_v !== 5'd3) begin
            $display("FAIL keyon_restep: got n=%0d k=%0d v=%0d expected n=1 k=5 v=3",
                     s_step_cnt, s_step_k, s_step_v); fails++;
        end
    endtask

    task automatic test_overrun();
        do_reset();
        set_rates(7'h38, 0, 7'h00);
        checks++;
        if (bus.overrun !== 1'b0) begin
            $display("FAIL overrun_init: got %b expected 0", bus.overrun); fails++;
        end
        // extra tick sampled at edge E0+4
        sweep(3, -1, '0);
        checks++;
        if (s_rd_cnt !== NVOICE || s_done_cnt !== 1 || s_done_k !== NVOICE + 1 ||
            s_busy_cnt !== NVOICE + 2 || s_seq_bad !== 0) begin
            $display("FAIL overrun_sweep: got rd=%0d done=%0d@%0d busy=%0d seq=%0d expected %0d 1@%0d %0d 0",
                     s_rd_cnt, s_done_cnt, s_done_k, s_busy_cnt, s_seq_bad, NVOICE, NVOICE + 1, NVOICE + 2); fails++;
        end
        checks++;
        if (bus.overrun !== OVR_EXP) begin
            $display("FAIL overrun_flag: got %b expected %b", bus.overrun, OVR_EXP); fails++;
        end
        sweep(-1, -1, '0);
        checks++;
        if (bus.overrun !== OVR_EXP || s_step_cnt !== 0) begin
            $display("FAIL overrun_sticky: got ovr=%b steps=%0d expected %b 0", bus.overrun, s_step_cnt, OVR_EXP); fails++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_rates(7'h38, -1, 7'h00);
        // next tick sampled at edge E0+NVOICE+2, the minimum spacing
        sweep(NVOICE + 1, -1, '0);
        checks++;
        if (s_rd_cnt !== NVOICE + 2 || s_busy_cnt !== NVOICE + 4 || s_done_cnt !== 1 || s_seq_bad !== 0) begin
            $display("FAIL b2b_sweep: got rd=%0d busy=%0d done=%0d seq=%0d expected %0d %0d 1 0",
                     s_rd_cnt, s_busy_cnt, s_done_cnt, s_seq_bad, NVOICE + 2, NVOICE + 4); fails++;
        end
        checks++;
        if (bus.overrun !== 1'b0) begin
            $display("FAIL b2b_no_overrun: got %b expected 0", bus.overrun); fails++;
        end
        repeat (NVOICE + 4) @(negedge clk);
        checks++;
        if ({bus.busy, bus.rom_read} !== 2'b00) begin
            $display("FAIL b2b_idle: got %b expected 00", {bus.busy, bus.rom_read}); fails++;
        end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.key_on      = 1'b0;
        bus.key_voice   = '0;
        set_rates(7'h38, -1, 7'h00);
        test_reset();
        test_rate00();
        test_rate23();
        test_zero_rate();
        test_keyon_collision();
        test_overrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
